ft_collision: RTL and testbench

FT_COLLISION -- requirements
Module: ft_collision

---
 rtl/ft_pkg.sv | 41 ++++
 rtl/ft_overlap_acc.sv | 45 ++++
 rtl/ft_collision.sv | 148 ++++++++++++++
 tb/tb_ft_collision.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared definitions for the ghost (fantome) logic: ghost FSM state codes used by
// fantome_layer and the collision FSM state type used by ft_collision.
// Build option: define FT_COLL_CATCH_EN to include the catch (freeze-power) feature.
package ft_pkg;

  // Ghost FSM state codes as driven on ft_state
  localparam logic [2:0] FT_INIT     = 3'd0;
  localparam logic [2:0] FT_IDLE     = 3'd1;
  localparam logic [2:0] FT_TELEPORT = 3'd2;
  localparam logic [2:0] FT_END      = 3'd3;

  localparam int unsigned OvlWidth = 8;

  localparam logic [10:0] CatchAward = 11'd100;
  localparam logic [10:0] CatchMax   = 11'd2047;

`ifdef FT_COLL_CATCH_EN
  typedef enum logic [2:0] {
    StArmed    = 3'd0,
    StHit      = 3'd1,
    StCatch    = 3'd2,
    StCooldown = 3'd3,
    StDead     = 3'd4
  } coll_state_t;
`else
  typedef enum logic [2:0] {
    StArmed    = 3'd0,
    StHit      = 3'd1,
    StCooldown = 3'd3,
    StDead     = 3'd4
  } coll_state_t;
`endif

  // Add the catch award, clamping at the 11-bit maximum
  function automatic logic [10:0] add_catch_points(input logic [10:0] points);
    logic [11:0] sum;
    sum = {1'b0, points} + {1'b0, CatchAward};
    return sum[11] ? CatchMax : sum[10:0];
  endfunction

endpackage

// File: rtl/ft_overlap_acc.sv
// Start-of-frame detection and per-frame ghost/Q*bert overlap pixel accumulation.
// The count clears on sof (the owner samples it on that same cycle) and on ft_end.
module ft_overlap_acc
  import ft_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         x_cnt,
  input  logic [9:0]          y_cnt,
  input  logic                fantome_hitbox,
  input  logic                qbert_hitbox,
  input  logic [2:0]          ft_state,
  input  logic                ft_end,
  input  logic                en,
  output logic                sof,
  output logic [OvlWidth-1:0] overlap
);

  logic [OvlWidth-1:0] overlap_q, overlap_d;
  logic                pix_hit;

  assign sof     = (x_cnt == 11'd0) && (y_cnt == 10'd0);
  assign pix_hit = en && fantome_hitbox && qbert_hitbox && (ft_state != FT_INIT);
  assign overlap = overlap_q;

  // Next count: clear on frame boundary or ghost end, else saturating increment
  always_comb begin
    overlap_d = overlap_q;
    if (ft_end || sof) begin
      overlap_d = '0;
    end else if (pix_hit && (overlap_q != {OvlWidth{1'b1}})) begin
      overlap_d = overlap_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      overlap_q <= '0;
    end else begin
      overlap_q <= overlap_d;
    end
  end

endmodule

// File: rtl/ft_collision.sv
// Ghost / Q*bert collision manager: evaluates the overlap count once per frame,
// pulses ft_hit (or ft_caught), tracks lives, cooldown and game over.
// Build option: define FT_COLL_CATCH_EN to include the catch feature; without it
// freeze_power simply suppresses evaluation, and ft_caught/catch_points read 0.
module ft_collision
  import ft_pkg::*;
#(
  parameter int unsigned HIT_THRESH      = 16,
  parameter int unsigned COOLDOWN_FRAMES = 60,
  parameter int unsigned LIVES_INIT      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x_cnt,
  input  logic [9:0]  y_cnt,
  input  logic        fantome_hitbox,
  input  logic        qbert_hitbox,
  input  logic [2:0]  ft_state,
  input  logic        ft_end,
  input  logic        freeze_power,
  input  logic        qb_on_sc,
  input  logic        game_restart,
  output logic        ft_hit,
  output logic        ft_caught,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic [10:0] catch_points
);

  localparam logic [2:0]  LivesInit = 3'(LIVES_INIT);
  localparam logic [15:0] CdLast    = 16'(COOLDOWN_FRAMES - 1);

  coll_state_t         state_q;
  logic [15:0]         cd_q;
  logic                sof;
  logic [OvlWidth-1:0] overlap;
  logic                acc_en;
  logic                eval_hit;

  // Hitbox inputs are ignored entirely once the game is over
  assign acc_en = (state_q != StDead);

  ft_overlap_acc u_acc (
    .clk            (clk),
    .reset          (reset),
    .x_cnt          (x_cnt),
    .y_cnt          (y_cnt),
    .fantome_hitbox (fantome_hitbox),
    .qbert_hitbox   (qbert_hitbox),
    .ft_state       (ft_state),
    .ft_end         (ft_end),
    .en             (acc_en),
    .sof            (sof),
    .overlap        (overlap)
  );

  // Frame-end evaluation; ft_end wins over a coincident sof
  assign eval_hit = sof && !ft_end && (state_q == StArmed) && !qb_on_sc &&
                    (32'(overlap) >= HIT_THRESH);

`ifndef FT_COLL_CATCH_EN
  assign ft_caught    = 1'b0;
  assign catch_points = '0;
`endif

  // Collision FSM with registered pulse, lives and score outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StArmed;
      cd_q         <= '0;
      ft_hit       <= 1'b0;
      lives        <= LivesInit;
      game_over    <= 1'b0;
`ifdef FT_COLL_CATCH_EN
      ft_caught    <= 1'b0;
      catch_points <= '0;
`endif
    end else begin
      ft_hit <= 1'b0;
`ifdef FT_COLL_CATCH_EN
      ft_caught <= 1'b0;
`endif
      unique case (state_q)
        StArmed: begin
          if (eval_hit) begin
`ifdef FT_COLL_CATCH_EN
            if (freeze_power) begin
              state_q      <= StCatch;
              ft_caught    <= 1'b1;
              catch_points <= add_catch_points(catch_points);
            end else begin
              state_q <= StHit;
              ft_hit  <= 1'b1;
              if (lives != 3'd0) lives <= lives - 3'd1;
            end
`else
            if (!freeze_power) begin
              state_q <= StHit;
              ft_hit  <= 1'b1;
              if (lives != 3'd0) lives <= lives - 3'd1;
            end
`endif
          end
        end
        StHit: begin
          // lives already holds the decremented value here
          cd_q <= '0;
          if (lives == 3'd0) begin
            state_q   <= StDead;
            game_over <= 1'b1;
          end else begin
            state_q <= StCooldown;
          end
        end
`ifdef FT_COLL_CATCH_EN
        StCatch: begin
          cd_q    <= '0;
          state_q <= StCooldown;
        end
`endif
        StCooldown: begin
          // The final cooldown sof re-arms without evaluating
          if (sof) begin
            if (cd_q == CdLast) begin
              cd_q    <= '0;
              state_q <= StArmed;
            end else begin
              cd_q <= cd_q + 16'd1;
            end
          end
        end
        StDead: begin
          game_over <= 1'b1;
          if (game_restart) begin
            lives     <= LivesInit;
            game_over <= 1'b0;
            state_q   <= StArmed;
`ifdef FT_COLL_CATCH_EN
            catch_points <= '0;
`endif
          end
        end
        default: state_q <= StArmed;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_collision.sv
// Directed self-checking bench for ft_collision (default parameters).
// Frames are compressed: a few pixel cycles followed by one x=0,y=0 cycle.
// Define FT_COLL_CATCH_EN for both bench and RTL to exercise the catch feature.
module tb_ft_collision;
  import ft_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        fantome_hitbox, qbert_hitbox;
  logic [2:0]  ft_state;
  logic        ft_end, freeze_power, qb_on_sc, game_restart;
  logic        ft_hit, ft_caught;
  logic [2:0]  lives;
  logic        game_over;
  logic [10:0] catch_points;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ft_collision dut (
    .clk            (clk),
    .reset          (reset),
    .x_cnt          (x_cnt),
    .y_cnt          (y_cnt),
    .fantome_hitbox (fantome_hitbox),
    .qbert_hitbox   (qbert_hitbox),
    .ft_state       (ft_state),
    .ft_end         (ft_end),
    .freeze_power   (freeze_power),
    .qb_on_sc       (qb_on_sc),
    .game_restart   (game_restart),
    .ft_hit         (ft_hit),
    .ft_caught      (ft_caught),
    .lives          (lives),
    .game_over      (game_over),
    .catch_points   (catch_points)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are stable when this returns
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic blank();
    x_cnt = 11'd5; y_cnt = 10'd5;
    fantome_hitbox = 1'b0; qbert_hitbox = 1'b0;
    tick();
  endtask

  task automatic sof_cycle();
    x_cnt = 11'd0; y_cnt = 10'd0;
    fantome_hitbox = 1'b0; qbert_hitbox = 1'b0;
    tick();
    x_cnt = 11'd5; y_cnt = 10'd5;
  endtask

  // n overlapping pixels, a blank pixel, then sof; returns just after the sof edge
  task automatic run_frame(input int n);
    for (int i = 0; i < n; i++) begin
      x_cnt = 11'(10 + i); y_cnt = 10'd7;
      fantome_hitbox = 1'b1; qbert_hitbox = 1'b1;
      tick();
    end
    blank();
    sof_cycle();
  endtask

  task automatic empty_frames(input int n);
    for (int i = 0; i < n; i++) begin
      blank();
      sof_cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    x_cnt = 11'd5; y_cnt = 10'd5;
    fantome_hitbox = 1'b0; qbert_hitbox = 1'b0;
    ft_state = FT_IDLE;
    ft_end = 1'b0; freeze_power = 1'b0; qb_on_sc = 1'b0; game_restart = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_hit", 32'(ft_hit), 0);
    check("rst_caught", 32'(ft_caught), 0);
    check("rst_lives", 32'(lives), 3);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_catch_points", 32'(catch_points), 0);
    check("rst_state", 32'(dut.state_q), 32'(StArmed));
    check("rst_overlap", 32'(dut.overlap), 0);
    reset = 1'b0;

    // Below threshold: 15 pixels
    run_frame(15);
    check("below_hit", 32'(ft_hit), 0);
    check("below_lives", 32'(lives), 3);
    check("below_overlap_clr", 32'(dut.overlap), 0);

    // Hit: 20 pixels, pulse one cycle after sof
    run_frame(20);
    check("hit1_pulse", 32'(ft_hit), 1);
    check("hit1_lives", 32'(lives), 2);
    blank();
    check("hit1_pulse_end", 32'(ft_hit), 0);
    check("hit1_cooldown", 32'(dut.state_q), 32'(StCooldown));

    // Two more hitting frames inside cooldown are ignored
    run_frame(20);
    check("cd_hit_a", 32'(ft_hit), 0);
    run_frame(20);
    check("cd_hit_b", 32'(ft_hit), 0);
    check("cd_lives", 32'(lives), 2);
    empty_frames(57);
    // 60th cooldown sof re-arms without evaluating
    run_frame(20);
    check("cd_last_sof_hit", 32'(ft_hit), 0);
    check("cd_rearmed", 32'(dut.state_q), 32'(StArmed));

    // Exactly at threshold
    run_frame(16);
    check("thresh_hit", 32'(ft_hit), 1);
    check("thresh_lives", 32'(lives), 1);
    blank();
    empty_frames(60);
    check("cd2_rearmed", 32'(dut.state_q), 32'(StArmed));

    // Last life
    run_frame(20);
    check("hit3_pulse", 32'(ft_hit), 1);
    check("hit3_lives", 32'(lives), 0);
    blank();
    check("dead_state", 32'(dut.state_q), 32'(StDead));
    check("dead_game_over", 32'(game_over), 1);
    run_frame(20);
    check("dead_no_hit", 32'(ft_hit), 0);
    check("dead_lives", 32'(lives), 0);
    check("dead_game_over_hold", 32'(game_over), 1);
    game_restart = 1'b1;
    tick();
    game_restart = 1'b0;
    check("restart_lives", 32'(lives), 3);
    check("restart_game_over", 32'(game_over), 0);
    check("restart_state", 32'(dut.state_q), 32'(StArmed));

    // Ghost in INIT state does not count overlap
    ft_state = FT_INIT;
    run_frame(20);
    check("init_no_hit", 32'(ft_hit), 0);
    ft_state = FT_TELEPORT;

    // ft_end coincident with sof after 30 pixels
    for (int i = 0; i < 30; i++) begin
      x_cnt = 11'(10 + i); y_cnt = 10'd9;
      fantome_hitbox = 1'b1; qbert_hitbox = 1'b1;
      tick();
    end
    check("pre_end_overlap", 32'(dut.overlap), 30);
    blank();
    ft_end = 1'b1;
    sof_cycle();
    ft_end = 1'b0;
    check("end_no_hit", 32'(ft_hit), 0);
    check("end_overlap_clr", 32'(dut.overlap), 0);
    check("end_state", 32'(dut.state_q), 32'(StArmed));

    // Q*bert on a stepping disc
    qb_on_sc = 1'b1;
    run_frame(20);
    qb_on_sc = 1'b0;
    check("qb_on_sc_no_hit", 32'(ft_hit), 0);
    check("qb_on_sc_lives", 32'(lives), 3);

    // Freeze power
    freeze_power = 1'b1;
    run_frame(20);
`ifdef FT_COLL_CATCH_EN
    check("catch_pulse", 32'(ft_caught), 1);
    check("catch_no_hit", 32'(ft_hit), 0);
    check("catch_points1", 32'(catch_points), 100);
    check("catch_lives", 32'(lives), 3);
    blank();
    check("catch_pulse_end", 32'(ft_caught), 0);
    for (int k = 2; k <= 21; k++) begin
      empty_frames(60);
      run_frame(20);
      if (k == 20) check("catch_points20", 32'(catch_points), 2000);
      blank();
    end
    check("catch_points_sat", 32'(catch_points), 2047);
    empty_frames(60);
`else
    check("freeze_no_hit", 32'(ft_hit), 0);
    check("freeze_no_catch", 32'(ft_caught), 0);
    check("freeze_lives", 32'(lives), 3);
    check("freeze_state", 32'(dut.state_q), 32'(StArmed));
    check("freeze_points", 32'(catch_points), 0);
`endif
    freeze_power = 1'b0;

    // game_restart ignored outside DEAD; reset mid-cooldown
    run_frame(20);
    check("hit4_pulse", 32'(ft_hit), 1);
    check("hit4_lives", 32'(lives), 2);
    blank();
    game_restart = 1'b1;
    tick();
    game_restart = 1'b0;
    check("restart_ignored_lives", 32'(lives), 2);
    check("restart_ignored_state", 32'(dut.state_q), 32'(StCooldown));
    empty_frames(3);
    check("cd_count_mid", 32'(dut.cd_q), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_state", 32'(dut.state_q), 32'(StArmed));
    check("mid_rst_lives", 32'(lives), 3);
    check("mid_rst_cd", 32'(dut.cd_q), 0);
    check("mid_rst_game_over", 32'(game_over), 0);
    check("mid_rst_hit", 32'(ft_hit), 0);
    check("mid_rst_points", 32'(catch_points), 0);
    run_frame(20);
    check("post_rst_hit", 32'(ft_hit), 1);
    check("post_rst_lives", 32'(lives), 2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
